program_encoder: RTL
====================

PROGRAM_ENCODER -- requirements
Module: program_encoder

Interface
REQ-001 SHALL have parameter DATA_BLOCK_MAX_SIZE, default 64: maximum data bytes per block.
REQ-002 SHALL have parameter DATA_BLOCK_ADDR_BITS, default $clog2(DATA_BLOCK_MAX_SIZE): index width into block_data.
REQ-003 SHALL have port clk  input  1: single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: begin encoding; sampled only when ready=1.
REQ-006 SHALL have port block_length  input  8: data byte count.
REQ-007 SHALL have port block_address  input  16: block load address.
REQ-008 SHALL have port block_type  input  8: block record type.
REQ-009 SHALL have port block_data  input  8 x DATA_BLOCK_MAX_SIZE: unpacked data byte array.
REQ-010 SHALL have port ready  output  1: idle, able to accept start.
REQ-011 SHALL have port done  output  1: one-cycle pulse when the last byte has been accepted.
REQ-012 SHALL have port out_data  output  8: stream byte.
REQ-013 SHALL have port out_valid  output  1: out_data valid.
REQ-014 SHALL have port out_ready  input  1: sink accepts byte; transfer = out_valid & out_ready at posedge.

Function
REQ-015 SHALL emit the byte stream: length, address[15:8], address[7:0], type, data[0..L-1], then checksum if enabled (REQ-030).
REQ-016 SHALL implement states IDLE, LENGTH, ADDR_HI, ADDR_LO, TYPE, DATA, CHECKSUM, and SHALL advance one state only on a transfer.
REQ-017 SHALL, on start with ready=1, capture length, address and type into registers; on the next edge ready=0, out_valid=1, and out_data=length byte.
REQ-018 SHALL clamp a captured length above DATA_BLOCK_MAX_SIZE to DATA_BLOCK_MAX_SIZE, both in the emitted length byte and in the data count.
REQ-019 SHALL read block_data[idx] live during DATA; the caller SHALL hold block_data stable from start until done.
REQ-020 SHALL hold out_data and out_valid unchanged while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one byte per cycle while out_ready is held at 1; out_data is registered and the next byte loads on the edge of the transfer.
REQ-022 SHALL, for L=0, go directly from TYPE to CHECKSUM or IDLE without emitting data bytes.
REQ-023 SHALL, on the last transfer, return to IDLE; on the following cycle out_valid=0, done=1 for exactly one cycle, and ready=1.
REQ-024 SHALL ignore start while ready=0.
REQ-025 SHALL accept a start asserted in the same cycle that done=1, beginning the next block without an idle gap.
REQ-026 SHALL keep its data index DATA_BLOCK_ADDR_BITS+1 wide so that L=DATA_BLOCK_MAX_SIZE does not wrap.

Reset
REQ-027 SHALL, on rst=0 asynchronously, drive state=IDLE, out_valid=0, out_data=0, done=0, ready=0 and clear all counters and captured registers.
REQ-028 SHALL set ready=1 on the first clock edge after rst deasserts.
REQ-029 SHALL abandon any in-flight block on reset with no partial completion and no done pulse.

Configuration
REQ-030 SHALL, with PROG_ENCODER_CHECKSUM_EN defined, append one byte equal to (0x100 - sum of all prior stream bytes mod 256) mod 256, accumulated on each transfer.
REQ-031 SHALL, without PROG_ENCODER_CHECKSUM_EN, omit the CHECKSUM state and accumulator; the stream is exactly 4+L bytes.

Verification
REQ-032 SHALL cover basic encoding: L=2, addr=0x1234, type=0x00, data={0xAA,0x55}, out_ready=1 -> bytes 02 12 34 00 AA 55 on consecutive cycles, then done pulse; with checksum enabled a 7th byte 0xB9.
REQ-033 SHALL cover backpressure: same block with out_ready toggling 1,0,0,1,... -> identical byte sequence, out_data stable while stalled, no byte duplicated or dropped.
REQ-034 SHALL cover empty and clamped lengths: L=0, addr=0xFFFF, type=0x01 -> 00 FF FF 01 (checksum 0x01 if enabled); L=200 with MAX=64 -> length byte 0x40 followed by 64 data bytes.
REQ-035 SHALL cover start handling: start while busy -> ignored, stream unchanged; start in the done cycle -> next length byte valid on the following edge.
REQ-036 SHALL cover reset mid-operation: rst=0 during DATA index 3 -> out_valid=0 immediately, no done pulse, ready=1 one edge after release, and a fresh block encodes correctly.

Source files
------------

// File: rtl/program_encoder.sv
// Serialises one program block as length, address hi/lo, type, data bytes over a valid/ready byte stream.
// Optional trailing checksum byte when PROG_ENCODER_CHECKSUM_EN is defined.
module program_encoder #(
    parameter int DATA_BLOCK_MAX_SIZE  = 64,
    parameter int DATA_BLOCK_ADDR_BITS = $clog2(DATA_BLOCK_MAX_SIZE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  block_length,
    input  logic [15:0] block_address,
    input  logic [7:0]  block_type,
    input  logic [7:0]  block_data [DATA_BLOCK_MAX_SIZE],
    output logic        ready,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int IDXW = DATA_BLOCK_ADDR_BITS + 1;
    localparam logic [IDXW-1:0] MAX_LEN = IDXW'(DATA_BLOCK_MAX_SIZE);

    // state names the byte currently presented on out_data
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LENGTH   = 3'd1,
        ADDR_HI  = 3'd2,
        ADDR_LO  = 3'd3,
        TYPE     = 3'd4,
`ifdef PROG_ENCODER_CHECKSUM_EN
        CHECKSUM = 3'd6,
`endif
        DATA     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic [IDXW-1:0] len_q, len_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      type_q, type_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] idx_next;
    logic [IDXW-1:0] len_clamp;
    logic            xfer;
    logic            go_end;
`ifdef PROG_ENCODER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      sum_acc;
`endif

    assign xfer      = out_valid_q & out_ready;
    assign idx_next  = idx_q + IDXW'(1);
    assign len_clamp = (block_length > 8'(DATA_BLOCK_MAX_SIZE)) ? MAX_LEN : IDXW'(block_length);
`ifdef PROG_ENCODER_CHECKSUM_EN
    assign sum_acc   = sum_q + out_data_q;
`endif

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        len_d       = len_q;
        addr_d      = addr_q;
        type_d      = type_q;
        idx_d       = idx_q;
        go_end      = 1'b0;
`ifdef PROG_ENCODER_CHECKSUM_EN
        sum_d       = xfer ? sum_acc : sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && ready_q) begin
                    len_d       = len_clamp;
                    addr_d      = block_address;
                    type_d      = block_type;
                    idx_d       = '0;
                    state_d     = LENGTH;
                    out_valid_d = 1'b1;
                    out_data_d  = 8'(len_clamp);
`ifdef PROG_ENCODER_CHECKSUM_EN
                    sum_d       = 8'h00;
`endif
                end
            end
            LENGTH: if (xfer) begin
                state_d    = ADDR_HI;
                out_data_d = addr_q[15:8];
            end
            ADDR_HI: if (xfer) begin
                state_d    = ADDR_LO;
                out_data_d = addr_q[7:0];
            end
            ADDR_LO: if (xfer) begin
                state_d    = TYPE;
                out_data_d = type_q;
            end
            TYPE: if (xfer) begin
                if (len_q != '0) begin
                    state_d    = DATA;
                    idx_d      = '0;
                    out_data_d = block_data[0];
                end else begin
                    go_end = 1'b1;
                end
            end
            DATA: if (xfer) begin
                if (idx_next < len_q) begin
                    idx_d      = idx_next;
                    out_data_d = block_data[idx_next[DATA_BLOCK_ADDR_BITS-1:0]];
                end else begin
                    go_end = 1'b1;
                end
            end
`ifdef PROG_ENCODER_CHECKSUM_EN
            CHECKSUM: if (xfer) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                done_d      = 1'b1;
            end
`endif
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (go_end) begin
`ifdef PROG_ENCODER_CHECKSUM_EN
            state_d    = CHECKSUM;
            out_data_d = 8'h00 - sum_acc;
`else
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
`endif
        end

        // ready lags reset release by one edge since it is registered from the next state
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            len_q       <= '0;
            addr_q      <= 16'h0000;
            type_q      <= 8'h00;
            idx_q       <= '0;
`ifdef PROG_ENCODER_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
`ifdef PROG_ENCODER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
